// File: rtl/cmp_share_if.sv
// rtl/cmp_share_if.sv - requester/response bundle for the shared comparator arbiter

interface cmp_share_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] b1_flat;
    logic [NREQ*WIDTH-1:0] b2_flat;
    logic [NREQ-1:0]       gnt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic                  resp_equal;
    logic                  resp_greater;
    logic                  resp_lesser;
    logic                  busy;

    modport master (
        output req, b1_flat, b2_flat, resp_ready,
        input  gnt, resp_valid, resp_id, resp_equal, resp_greater, resp_lesser, busy
    );

    modport slave (
        input  req, b1_flat, b2_flat, resp_ready,
        output gnt, resp_valid, resp_id, resp_equal, resp_greater, resp_lesser, busy
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - round-robin shared magnitude comparator (SIGNED_CMP_EN selects two's complement compare)

module cmp_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    cmp_share_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic             found;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   pick_nxt;
    logic [IDW-1:0]   cand;
    int               idx;
    logic             arb;
    logic             cmp_eq, cmp_gt, cmp_lt;

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx  = (int'(ptr_q) + i) % NREQ;
            cand = IDW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_nxt = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
    end

`ifdef SIGNED_CMP_EN
    assign cmp_eq = ($signed(op1_q) == $signed(op2_q));
    assign cmp_gt = ($signed(op1_q) >  $signed(op2_q));
    assign cmp_lt = ($signed(op1_q) <  $signed(op2_q));
`else
    assign cmp_eq = (op1_q == op2_q);
    assign cmp_gt = (op1_q >  op2_q);
    assign cmp_lt = (op1_q <  op2_q);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        op1_d   = op1_q;
        op2_d   = op2_q;
        valid_d = valid_q;
        id_d    = id_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        arb     = 1'b0;

        case (state_q)
            IDLE: begin
                arb = found;
            end
            CAP: begin
                eq_d    = cmp_eq;
                gt_d    = cmp_gt;
                lt_d    = cmp_lt;
                id_d    = sel_q;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = IDLE;
                    arb     = found;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A handshake edge with pending requests re-arbitrates immediately.
        if (arb) begin
            gnt_d   = NREQ'(1) << pick;
            op1_d   = bus.b1_flat[pick*WIDTH +: WIDTH];
            op2_d   = bus.b2_flat[pick*WIDTH +: WIDTH];
            sel_d   = pick;
            ptr_d   = pick_nxt;
            state_d = CAP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.resp_valid   = valid_q;
    assign bus.resp_id      = id_q;
    assign bus.resp_equal   = eq_q;
    assign bus.resp_greater = gt_q;
    assign bus.resp_lesser  = lt_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - randomized and directed bench against a transaction-level reference model

module tb_cmp_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    typedef struct {
        int         id;
        logic [2:0] flags;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_share_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ptr_m = 0;
    exp_t exp_q[$];
    int   gnt_log[$];
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Flags as {equal, greater, lesser}, straight from integer arithmetic.
    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ia, ib;
`ifdef SIGNED_CMP_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        return {ia == ib, ia > ib, ia < ib};
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: inputs held across the edge, model advanced, outputs checked at negedge.
    task automatic tick();
        logic [NREQ-1:0]       r;
        logic                  rdy, rs, arb;
        logic [NREQ*WIDTH-1:0] a1, a2;
        logic [NREQ-1:0]       eg;
        exp_t                  e;
        int                    k;
        r   = bus.req;
        rdy = bus.resp_ready;
        rs  = rst_n;
        a1  = bus.b1_flat;
        a2  = bus.b2_flat;
        @(posedge clk);
        @(negedge clk);
        eg  = '0;
        arb = 1'b0;
        if (!rs) begin
            exp_q.delete();
            ptr_m = 0;
        end else begin
            if (prev_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            if ((|r) && exp_q.size() == 0) begin
                k = -1;
                for (int i = 0; i < NREQ; i++)
                    if (k < 0 && r[(ptr_m + i) % NREQ]) k = (ptr_m + i) % NREQ;
                eg[k] = 1'b1;
                ptr_m = (k + 1) % NREQ;
                arb   = 1'b1;
                e.id    = k;
                e.flags = ref_cmp(a1[k*WIDTH +: WIDTH], a2[k*WIDTH +: WIDTH]);
                exp_q.push_back(e);
            end
        end
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_q.size() > 0 && !arb));
        check("busy", 32'(bus.busy), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0 && !arb) begin
            check("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
            check("flags", 32'({bus.resp_equal, bus.resp_greater, bus.resp_lesser}), 32'(exp_q[0].flags));
        end else begin
            check("flags_idle", 32'({bus.resp_equal, bus.resp_greater, bus.resp_lesser}), 32'd0);
        end
        if (bus.gnt != '0) gnt_log.push_back(onehot_idx(bus.gnt));
        prev_valid = bus.resp_valid;
        bus.req    = bus.req & ~bus.gnt;
    endtask

    task automatic drain();
        bus.req        = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || bus.busy); i++) tick();
        check("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] last_gnt;
        bus.req        = '1;
        bus.b1_flat    = '0;
        bus.b2_flat    = '0;
        bus.resp_ready = 1'b1;

        // Reset held with all requests active
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_no_grants", 32'(gnt_log.size()), 32'd0);
        bus.req = '0;
        rst_n   = 1'b1;
        tick();

        // Single requester 2
        bus.b1_flat[2*WIDTH +: WIDTH] = 4'b1010;
        bus.b2_flat[2*WIDTH +: WIDTH] = 4'b0011;
        bus.req = 4'b0100;
        tick();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        tick();
        check("single_valid", 32'(bus.resp_valid), 32'd1);
        check("single_id", 32'(bus.resp_id), 32'd2);
        check("single_gt", 32'(bus.resp_greater), 32'd1);
        drain();

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gnt_log.delete();
        bus.req = '1;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.req = ~bus.gnt;
        end
        check("rr_count", 32'(gnt_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("rr_order", 32'(gnt_log[i]), 32'(i % NREQ));
        drain();

        // Backpressure with equal operands
        bus.b1_flat[1*WIDTH +: WIDTH] = 4'b0110;
        bus.b2_flat[1*WIDTH +: WIDTH] = 4'b0110;
        bus.req        = 4'b0010;
        bus.resp_ready = 1'b0;
        tick();
        bus.req = 4'b1101;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_equal", 32'(bus.resp_equal), 32'd1);
            check("bp_id", 32'(bus.resp_id), 32'd1);
            check("bp_no_gnt", 32'(bus.gnt), 32'd0);
        end
        bus.resp_ready = 1'b1;
        drain();

        // Reset while a response is pending
        bus.req        = 4'b1000;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(bus.resp_valid), 32'd0);
        rst_n          = 1'b1;
        bus.req        = '0;
        bus.resp_ready = 1'b1;
        tick();
        check("midrst_idle", 32'(bus.busy), 32'd0);
        bus.req = '1;
        tick();
        check("midrst_ptr0", 32'(bus.gnt), 32'h1);
        drain();

        // Signedness corner
        bus.b1_flat[0 +: WIDTH] = 4'b1000;
        bus.b2_flat[0 +: WIDTH] = 4'b0111;
        bus.req = 4'b0001;
        tick();
        tick();
`ifdef SIGNED_CMP_EN
        check("sign_lesser", 32'(bus.resp_lesser), 32'd1);
`else
        check("sign_greater", 32'(bus.resp_greater), 32'd1);
`endif
        drain();

        // Randomized traffic
        last_gnt = '0;
        for (int c = 0; c < 600; c++) begin
            bus.b1_flat    = NREQ*WIDTH'($urandom);
            bus.b2_flat    = ($urandom_range(0, 3) == 0) ? bus.b1_flat : NREQ*WIDTH'($urandom);
            bus.resp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && !last_gnt[i] && $urandom_range(0, 2) == 0) bus.req[i] = 1'b1;
                else if (bus.req[i] && $urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            tick();
            rst_n    = 1'b1;
            last_gnt = bus.gnt;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
